// File: rtl/rename_stage.sv
// rtl/rename_stage.sv - decode/rename stage: RAT lookup, free-list allocation, one-entry output register
// Maps architectural to physical registers speculatively; frees arrive from commit.
module rename_stage #(
  parameter int ARCH_REGS = 32,
  parameter int PHYS_REGS = 64,
  parameter int PREG_W    = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instruction,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instruction,
  output logic [PREG_W-1:0] out_prs1,
  output logic [PREG_W-1:0] out_prs2,
  output logic [PREG_W-1:0] out_prd,
  output logic [PREG_W-1:0] out_old_prd,
  output logic              out_has_dest,
  input  logic              free_valid,
  input  logic [PREG_W-1:0] free_preg
);

  localparam int FL_DEPTH = PHYS_REGS - ARCH_REGS;
  localparam int FL_W     = $clog2(FL_DEPTH);
  localparam int CNT_W    = $clog2(FL_DEPTH + 1);

  logic [PREG_W-1:0] r_rat [ARCH_REGS];
  logic [PREG_W-1:0] r_fl  [FL_DEPTH];
  logic [FL_W-1:0]   r_head;
  logic [FL_W-1:0]   r_tail;
  logic [CNT_W-1:0]  r_count;

  logic              r_out_valid;
  logic [31:0]       r_out_instruction;
  logic [PREG_W-1:0] r_out_prs1;
  logic [PREG_W-1:0] r_out_prs2;
  logic [PREG_W-1:0] r_out_prd;
  logic [PREG_W-1:0] r_out_old_prd;
  logic              r_out_has_dest;

  logic [4:0] w_rs1;
  logic [4:0] w_rs2;
  logic [4:0] w_rd;
  logic [6:0] w_opcode;
  logic       w_has_dest;
  logic       w_accept;
  logic       w_pop;

  assign w_rs1    = in_instruction[19:15];
  assign w_rs2    = in_instruction[24:20];
  assign w_rd     = in_instruction[11:7];
  assign w_opcode = in_instruction[6:0];

  always_comb begin
    w_has_dest = 1'b0;
    case (w_opcode)
      7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
      7'b0000011, 7'b0010011, 7'b0110011: w_has_dest = (w_rd != 5'd0);
      default:                            w_has_dest = 1'b0;
    endcase
  end

  // Stalls even for no-dest instructions when empty, keeping in_ready independent of the word.
  assign in_ready = (!r_out_valid || out_ready) && (r_count != '0);
  assign w_accept = in_valid && in_ready;
  assign w_pop    = w_accept && w_has_dest;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ARCH_REGS; i++) r_rat[i] <= PREG_W'(i);
      for (int i = 0; i < FL_DEPTH; i++) r_fl[i] <= PREG_W'(ARCH_REGS + i);
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= CNT_W'(FL_DEPTH);
    end else begin
      if (w_pop) begin
        r_rat[w_rd] <= r_fl[r_head];
        r_head      <= r_head + 1'b1;
      end
      if (free_valid) begin
        r_fl[r_tail] <= free_preg;
        r_tail       <= r_tail + 1'b1;
      end
      case ({w_pop, free_valid})
        2'b10:   r_count <= r_count - 1'b1;
        2'b01:   r_count <= r_count + 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid       <= 1'b0;
      r_out_instruction <= '0;
      r_out_prs1        <= '0;
      r_out_prs2        <= '0;
      r_out_prd         <= '0;
      r_out_old_prd     <= '0;
      r_out_has_dest    <= 1'b0;
    end else if (w_accept) begin
      r_out_valid       <= 1'b1;
      r_out_instruction <= in_instruction;
      r_out_prs1        <= r_rat[w_rs1];
      r_out_prs2        <= r_rat[w_rs2];
      r_out_prd         <= w_has_dest ? r_fl[r_head] : '0;
      r_out_old_prd     <= w_has_dest ? r_rat[w_rd] : '0;
      r_out_has_dest    <= w_has_dest;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Commit must never overfill the list or hand back an architectural-reset register.
  always_ff @(posedge clk) begin
    if (!rst && free_valid) begin
      assert (r_count != CNT_W'(FL_DEPTH) && free_preg >= PREG_W'(ARCH_REGS));
    end
  end

  assign out_valid       = r_out_valid;
  assign out_instruction = r_out_instruction;
  assign out_prs1        = r_out_prs1;
  assign out_prs2        = r_out_prs2;
  assign out_prd         = r_out_prd;
  assign out_old_prd     = r_out_old_prd;
  assign out_has_dest    = r_out_has_dest;

endmodule

// File: tb/tb_rename_stage.sv
// tb/tb_rename_stage.sv - self-checking bench for rename_stage
// Reference model: RAT array plus free-list queue, updated per accepted instruction.
module tb_rename_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instruction;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instruction;
  logic [5:0]  out_prs1;
  logic [5:0]  out_prs2;
  logic [5:0]  out_prd;
  logic [5:0]  out_old_prd;
  logic        out_has_dest;
  logic        free_valid;
  logic [5:0]  free_preg;

  rename_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_instruction(in_instruction),
    .out_valid(out_valid), .out_ready(out_ready), .out_instruction(out_instruction),
    .out_prs1(out_prs1), .out_prs2(out_prs2), .out_prd(out_prd),
    .out_old_prd(out_old_prd), .out_has_dest(out_has_dest),
    .free_valid(free_valid), .free_preg(free_preg)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  int          m_rat [32];
  int          m_fl [$];
  int          m_ret [$];
  bit          m_ov;
  logic [31:0] m_ins;
  int          m_p1, m_p2, m_pd, m_old;
  bit          m_hd;

  localparam logic [31:0] ADDI_X1 = 32'h00500093;
  localparam logic [31:0] ADD_X2  = 32'h00108133;
  localparam logic [31:0] SW      = 32'h00112023;
  localparam logic [31:0] ADDI_X3 = 32'h00500193;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit writes_reg(input logic [31:0] ins);
    int op = int'(ins[6:0]);
    bool_op: begin end
    return (op inside {'h37, 'h17, 'h6f, 'h67, 'h03, 'h13, 'h33}) && (ins[11:7] != 5'd0);
  endfunction

  function automatic logic [31:0] rnd_ins();
    logic [6:0]  ops [10];
    logic [31:0] r;
    ops = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h03, 7'h13, 7'h33, 7'h23, 7'h63, 7'h73};
    r = $urandom;
    r[6:0] = ops[$urandom_range(0, 9)];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_rat[i] = i;
    m_fl.delete();
    for (int i = 32; i < 64; i++) m_fl.push_back(i);
    m_ret.delete();
    m_ov = 0; m_ins = 0; m_p1 = 0; m_p2 = 0; m_pd = 0; m_old = 0; m_hd = 0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".out_valid"}, out_valid, m_ov);
    chk({tag, ".ins"}, out_instruction, m_ins);
    chk({tag, ".prs1"}, out_prs1, m_p1);
    chk({tag, ".prs2"}, out_prs2, m_p2);
    chk({tag, ".prd"}, out_prd, m_pd);
    chk({tag, ".old_prd"}, out_old_prd, m_old);
    chk({tag, ".has_dest"}, out_has_dest, m_hd);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; in_instruction = ADDI_X1; out_ready = 1'b1;
    free_valid = 1'b0; free_preg = '0;
    @(posedge clk); #1;
    model_reset();
    check_outputs("reset");
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    #1 chk("reset.in_ready", in_ready, 1'b1);
  endtask

  task automatic step(input string tag, input bit v, input logic [31:0] ins,
                      input bit ordy, input bit fv, input int fp);
    bit exp_rdy;
    int rd;
    @(negedge clk);
    in_valid = v; in_instruction = ins; out_ready = ordy;
    free_valid = fv; free_preg = 6'(fp);
    #1;
    exp_rdy = (!m_ov || ordy) && (m_fl.size() != 0);
    chk({tag, ".in_ready"}, in_ready, exp_rdy);
    if (v && exp_rdy) begin
      rd    = int'(ins[11:7]);
      m_ov  = 1;
      m_ins = ins;
      m_p1  = m_rat[ins[19:15]];
      m_p2  = m_rat[ins[24:20]];
      m_hd  = writes_reg(ins);
      if (m_hd) begin
        m_pd  = m_fl.pop_front();
        m_old = m_rat[rd];
        m_rat[rd] = m_pd;
        if (m_old >= 32) m_ret.push_back(m_old);
      end else begin
        m_pd = 0; m_old = 0;
      end
    end else if (ordy) begin
      m_ov = 0;
    end
    if (fv) m_fl.push_back(fp);
    @(posedge clk); #1;
    check_outputs(tag);
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_instruction = '0; out_ready = 1'b0;
    free_valid = 1'b0; free_preg = '0;
    model_reset();

    reset_dut();
    step("addi", 1, ADDI_X1, 1, 0, 0);
    chk("tp.addi.prd", out_prd, 32);
    chk("tp.addi.old", out_old_prd, 1);
    step("add", 1, ADD_X2, 1, 0, 0);
    chk("tp.add.prs1", out_prs1, 32);
    chk("tp.add.prs2", out_prs2, 32);
    chk("tp.add.prd", out_prd, 33);
    step("sw", 1, SW, 1, 0, 0);
    chk("tp.sw.prs1", out_prs1, 33);
    chk("tp.sw.has_dest", out_has_dest, 0);

    for (int i = 0; i < 5; i++) step("stall", 1, ADDI_X3, 0, 0, 0);
    step("release", 1, ADDI_X3, 1, 0, 0);
    chk("tp.release.prd", out_prd, 34);
    step("drain", 0, ADDI_X3, 1, 0, 0);

    reset_dut();
    for (int i = 0; i < 32; i++) step("exhaust", 1, ADDI_X1, 1, 0, 0);
    chk("tp.exhaust.last_prd", out_prd, 63);
    step("empty_free", 1, ADDI_X1, 1, 1, 32);
    step("refill", 1, ADDI_X1, 1, 0, 0);
    chk("tp.refill.prd", out_prd, 32);

    reset_dut();
    for (int i = 0; i < 27; i++) step("fill27", 1, ADDI_X1, 1, 0, 0);
    step("pushpop", 1, ADDI_X1, 1, 1, 40);
    chk("tp.pushpop.prd", out_prd, 59);
    for (int i = 0; i < 5; i++) step("tail", 1, ADDI_X1, 1, 0, 0);
    chk("tp.tail.prd", out_prd, 40);
    step("tail_empty", 1, ADDI_X1, 1, 0, 0);

    reset_dut();
    for (int i = 0; i < 400; i++) begin
      bit fv;
      int fp;
      fv = (m_ret.size() != 0) && ($urandom_range(0, 2) == 0);
      fp = fv ? m_ret.pop_front() : 0;
      step("rand", ($urandom_range(0, 3) != 0), rnd_ins(), ($urandom_range(0, 3) != 0), fv, fp);
    end

    step("pre_rst", 1, ADDI_X3, 0, 0, 0);
    reset_dut();
    step("post_rst", 1, ADDI_X1, 1, 0, 0);
    chk("tp.post_rst.prd", out_prd, 32);

    @(negedge clk);
    in_valid = 1'b0; free_valid = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
